// File: rtl/reduceron_uart_report.sv
// Reports Reduceron core I/O writes ("W aaaa dddd") and finish results ("R rrrrr")
// as ASCII lines on a UART 8N1 transmitter. A small FIFO absorbs write bursts.
module reduceron_uart_report #(
  parameter int BAUD_DIV  = 434,
  parameter int FIFO_LOG2 = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        iowrite,
  input  logic [13:0] ioaddr,
  input  logic [13:0] iowd,
  input  logic        finish,
  input  logic [16:0] result,
  output logic        uart_txd,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int BW    = $clog2(BAUD_DIV + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [27:0]          r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wr;
  logic [FIFO_LOG2-1:0] r_rd;
  logic [FIFO_LOG2:0]   r_count;
  logic                 r_finish_q;
  logic                 r_pend;
  logic [16:0]          r_result;
  logic [1:0]           r_state;
  logic                 r_kind;
  logic [27:0]          r_line;
  logic [3:0]           r_idx;
  logic [9:0]           r_shift;
  logic [3:0]           r_bit;
  logic [BW-1:0]        r_baud;
  logic                 r_txd;
  logic                 r_overflow;
  logic [7:0]           r_drops;

  logic       w_pop;
  logic       w_full;
  logic       w_push;
  logic       w_drop;
  logic       w_edge;
  logic       w_bit_end;
  logic [3:0] w_last_idx;
  logic [7:0] w_char;

  // Writes are only popped from IDLE, so a push into a full FIFO is legal in that cycle.
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_full     = (r_count == (FIFO_LOG2 + 1)'(DEPTH));
  assign w_push     = iowrite && (!w_full || w_pop);
  assign w_drop     = iowrite && w_full && !w_pop;
  assign w_edge     = finish && !r_finish_q;
  assign w_bit_end  = (r_baud == BW'(BAUD_DIV - 1));
  assign w_last_idx = r_kind ? 4'd8 : 4'd12;

  assign uart_txd   = r_txd;
  assign busy       = (r_state != S_IDLE) || (r_count != '0) || r_pend;
  assign overflow   = r_overflow;
  assign drop_count = r_drops;
  assign dbg_state  = r_state;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // W line: address in r_line[27:14], data in r_line[13:0]. R line: result in r_line[16:0].
  always_comb begin
    w_char = 8'h0A;
    if (!r_kind) begin
      case (r_idx)
        4'd0:    w_char = 8'h57;
        4'd1:    w_char = 8'h20;
        4'd2:    w_char = hex_char({2'b00, r_line[27:26]});
        4'd3:    w_char = hex_char(r_line[25:22]);
        4'd4:    w_char = hex_char(r_line[21:18]);
        4'd5:    w_char = hex_char(r_line[17:14]);
        4'd6:    w_char = 8'h20;
        4'd7:    w_char = hex_char({2'b00, r_line[13:12]});
        4'd8:    w_char = hex_char(r_line[11:8]);
        4'd9:    w_char = hex_char(r_line[7:4]);
        4'd10:   w_char = hex_char(r_line[3:0]);
        4'd11:   w_char = 8'h0D;
        default: w_char = 8'h0A;
      endcase
    end else begin
      case (r_idx)
        4'd0:    w_char = 8'h52;
        4'd1:    w_char = 8'h20;
        4'd2:    w_char = hex_char({3'b000, r_line[16]});
        4'd3:    w_char = hex_char(r_line[15:12]);
        4'd4:    w_char = hex_char(r_line[11:8]);
        4'd5:    w_char = hex_char(r_line[7:4]);
        4'd6:    w_char = hex_char(r_line[3:0]);
        4'd7:    w_char = 8'h0D;
        default: w_char = 8'h0A;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr] <= {ioaddr, iowd};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drops    <= 8'd0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drops != 8'hFF) r_drops <= r_drops + 8'd1;
      end
    end
  end

  // A new finish edge wins over clearing, so a result arriving as an R line starts is kept.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_finish_q <= 1'b0;
      r_pend     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_finish_q <= finish;
      if (w_edge) begin
        r_result <= result;
        r_pend   <= 1'b1;
      end else if ((r_state == S_IDLE) && (r_count == '0) && r_pend) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kind  <= 1'b0;
      r_line  <= '0;
      r_idx   <= '0;
      r_shift <= '1;
      r_bit   <= '0;
      r_baud  <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (r_count != '0) begin
            r_line  <= r_mem[r_rd];
            r_kind  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_LOAD;
          end else if (r_pend) begin
            r_line  <= {11'd0, r_result};
            r_kind  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_shift <= {1'b1, w_char, 1'b0};
          r_txd   <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
              r_txd <= 1'b1;
              if (r_idx == w_last_idx) begin
                r_state <= S_GAP;
              end else begin
                r_idx   <= r_idx + 4'd1;
                r_state <= S_LOAD;
              end
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_shift <= {1'b1, r_shift[9:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reduceron_uart_report.sv
// Bench for reduceron_uart_report: a line-level model predicts bytes and status,
// a UART decoder pops the expected byte queue as characters arrive.
module tb_reduceron_uart_report;

  localparam int B     = 4;
  localparam int DEPTH = 4;
  localparam int CH    = 10 * B + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iowrite = 1'b0;
  logic [13:0] ioaddr = '0;
  logic [13:0] iowd = '0;
  logic        finish = 1'b0;
  logic [16:0] result = '0;
  logic        uart_txd;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [27:0] m_fifo[$];
  bit          m_pend, m_fq, m_ovf, m_rst_seen, started;
  logic [16:0] m_res;
  int          m_cnt, m_drops, m_sz;
  bit          m_idle, m_pop;
  logic [27:0] m_e;

  bit          in_frame;
  int          k;
  logic        cur;
  bit          bad;
  logic [9:0]  bits;
  logic [7:0]  got;

  reduceron_uart_report #(.BAUD_DIV(B), .FIFO_LOG2(2)) dut (
    .CLOCK_50(clk), .reset(rst), .iowrite(iowrite), .ioaddr(ioaddr), .iowd(iowd),
    .finish(finish), .result(result), .uart_txd(uart_txd), .busy(busy),
    .overflow(overflow), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  task automatic push_w(input logic [13:0] a, input logic [13:0] d);
    exp_q.push_back(8'h57);
    exp_q.push_back(8'h20);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexc((int'(a) >> (4 * i)) & 15));
    exp_q.push_back(8'h20);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexc((int'(d) >> (4 * i)) & 15));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push_r(input logic [16:0] r);
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h20);
    for (int i = 4; i >= 0; i--) exp_q.push_back(hexc((int'(r) >> (4 * i)) & 15));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: a line occupies the transmitter for n characters plus LOAD/GAP overhead.
  always @(posedge clk) begin
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_pend = 0; m_fq = 0; m_ovf = 0; m_cnt = 0; m_drops = 0;
      m_rst_seen = 1; started = 1;
    end else begin
      m_rst_seen = 0;
      m_sz   = m_fifo.size();
      m_idle = (m_cnt == 0);
      m_pop  = m_idle && (m_sz > 0);
      if (m_pop) begin
        m_e = m_fifo.pop_front();
        push_w(m_e[27:14], m_e[13:0]);
        m_cnt = 13 * CH + 1;
      end else if (m_idle && m_pend) begin
        push_r(m_res);
        m_pend = 0;
        m_cnt = 9 * CH + 1;
      end else if (m_cnt > 0) begin
        m_cnt--;
      end
      if (iowrite) begin
        if (m_sz < DEPTH || m_pop) m_fifo.push_back({ioaddr, iowd});
        else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (finish && !m_fq) begin
        m_res  = result;
        m_pend = 1;
      end
      m_fq = finish;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", int'(busy), int'(m_cnt != 0 || m_fifo.size() > 0 || m_pend));
      check("overflow", int'(overflow), int'(m_ovf));
      check("drop_count", int'(drop_count), m_drops);
      if (m_rst_seen) check("txd_after_reset", int'(uart_txd), 1);
    end
  end

  // UART decoder: one sample per cycle, each bit must hold for exactly B samples.
  always @(negedge clk) begin
    if (rst || !started) begin
      in_frame = 0;
    end else if (!in_frame && uart_txd === 1'b0) begin
      in_frame = 1;
      k = 0;
      bad = 0;
    end
    if (in_frame) begin
      if (k % B == 0) cur = uart_txd;
      else if (uart_txd !== cur) bad = 1;
      if (k % B == B - 1) begin
        check("bit_hold", int'(bad), 0);
        bits[k / B] = cur;
        bad = 0;
      end
      if (k == 10 * B - 1) begin
        check("stop_bit", int'(bits[9]), 1);
        got = bits[8:1];
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL uart_byte at %0t: got %02h expected nothing", $time, got);
        end else begin
          check("uart_byte", int'(got), int'(exp_q.pop_front()));
        end
        in_frame = 0;
      end
      k++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [13:0] a, input logic [13:0] d);
    iowrite = 1; ioaddr = a; iowd = d;
    tick();
    iowrite = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(m_cnt == 0 && m_fifo.size() == 0 && !m_pend && exp_q.size() == 0 && !in_frame)
           && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_idle at %0t: still busy after %0d cycles, limit %0d", $time, n, budget);
    end
    tick();
  endtask

  initial begin
    tick(); tick(); tick();
    rst = 0;
    repeat (10) tick();

    write_one(14'h0012, 14'h3ABC);
    wait_idle(2000);

    finish = 1; result = 17'h1F00D;
    repeat (500) tick();
    finish = 0;
    tick();
    finish = 1;
    tick();
    wait_idle(2000);
    finish = 0;
    tick();

    for (int i = 1; i <= 6; i++) write_one(14'(i * 16), 14'(i));
    wait_idle(5000);

    iowrite = 1; ioaddr = 14'h1234; iowd = 14'h0FED; finish = 1; result = 17'h12345;
    tick();
    iowrite = 0;
    repeat (100) tick();
    finish = 0;
    tick();
    finish = 1; result = 17'h0BEEF;
    tick();
    wait_idle(3000);
    finish = 0;
    tick();

    write_one(14'h2AAA, 14'h1555);
    for (int n = 0; n < 200 && uart_txd !== 1'b0; n++) tick();
    rst = 1;
    tick();
    rst = 0;
    repeat (20) tick();

    rst = 1; tick(); rst = 0;
    iowrite = 1;
    for (int i = 0; i < 300; i++) begin
      ioaddr = 14'($urandom); iowd = 14'($urandom);
      tick();
    end
    iowrite = 0;
    wait_idle(8000);
    rst = 1; tick(); rst = 0;
    repeat (5) tick();

    for (int i = 0; i < 3000; i++) begin
      iowrite = ($urandom_range(0, 39) == 0);
      ioaddr  = 14'($urandom);
      iowd    = 14'($urandom);
      if ($urandom_range(0, 99) == 0) finish = ~finish;
      result  = 17'($urandom);
      tick();
    end
    iowrite = 0;
    wait_idle(20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
